// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the hazard unit.
// Types are sized to the widest supported configuration; modules zero-extend into them.
package hazard_pkg;
   localparam int MAX_RA_W = 8;
   localparam int MAX_SEL_W = 8;
   localparam int FWD_RF = 0;

   typedef struct packed {
      logic                valid;
      logic [MAX_RA_W-1:0] rd;
      logic                rd_we;
      logic                is_load;
   } track_entry_t;

   typedef struct packed {
      logic [MAX_SEL_W-1:0] stage;
      logic                 from_dm;
   } fwd_sel_t;

   function automatic int sel_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/hazard_src_resolve.sv
// hazard_src_resolve: youngest-match forwarding resolver for one source operand.
module hazard_src_resolve
   import hazard_pkg::*;
#(
   parameter int FWD_DEPTH    = 2,
   parameter int LOAD_LATENCY = 1
) (
   input  track_entry_t [FWD_DEPTH:1] entries,
   input  logic [MAX_RA_W-1:0]        rs,
   input  logic                       rs_en,
   output fwd_sel_t                   sel,
   output logic                       load_use
);
   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      sel = '{stage: MAX_SEL_W'(FWD_RF), from_dm: 1'b0};
      load_use = 1'b0;
      for (int i = FWD_DEPTH; i >= 1; i--) begin
         if (rs_en && entries[i].valid && entries[i].rd_we && entries[i].rd != '0 && entries[i].rd == rs) begin
            sel = '{stage: MAX_SEL_W'(i), from_dm: entries[i].is_load};
            load_use = entries[i].is_load && i < 1 + LOAD_LATENCY;
         end
      end
   end
endmodule

// File: rtl/hazard_unit_param.sv
// hazard_unit_param: in-flight destination tracker, per-source forwarding selects and load-use stall.
module hazard_unit_param
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter int NUM_SRC      = 2,
   parameter int FWD_DEPTH    = 2,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 32,
   localparam int SEL_W       = sel_w(FWD_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          dec_valid,
   input  logic [REG_ADDR_W-1:0]         dec_rd,
   input  logic                          dec_rd_we,
   input  logic                          dec_is_load,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs,
   input  logic [NUM_SRC-1:0]            dec_rs_used,
   input  logic                          flush,
   output logic                          f_to_d_enable_ff,
   output logic                          d_to_e_bubble,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_stage,
   output logic [NUM_SRC-1:0]            fwd_from_dm,
   output logic [CNT_W-1:0]              stall_cycles
);
   track_entry_t [FWD_DEPTH:1] ent;
   fwd_sel_t [NUM_SRC-1:0] sel;
   logic [NUM_SRC-1:0] load_use;
   logic [NUM_SRC-1:0] sel_unused;
   logic stall;

   if (LOAD_LATENCY >= FWD_DEPTH || LOAD_LATENCY < 1 || NUM_SRC == 0 || REG_ADDR_W > MAX_RA_W ||
       SEL_W >= MAX_SEL_W) begin : g_bad
      $error("hazard_unit_param: illegal parameter combination");
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      hazard_src_resolve #(
         .FWD_DEPTH(FWD_DEPTH),
         .LOAD_LATENCY(LOAD_LATENCY)
      ) u_res (
         .entries(ent),
         .rs(MAX_RA_W'(dec_rs[k*REG_ADDR_W +: REG_ADDR_W])),
         .rs_en(dec_valid & dec_rs_used[k]),
         .sel(sel[k]),
         .load_use(load_use[k])
      );
      assign fwd_stage[k*SEL_W +: SEL_W] = sel[k].stage[SEL_W-1:0];
      assign fwd_from_dm[k] = sel[k].from_dm;
      assign sel_unused[k] = |sel[k].stage[MAX_SEL_W-1:SEL_W];
   end

   // Flush squashes the decode instruction, so it can never stall.
   assign stall = |load_use & ~flush;
   assign f_to_d_enable_ff = ~stall;
   assign d_to_e_bubble = stall | flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent <= '0;
         stall_cycles <= '0;
      end else begin
         for (int i = FWD_DEPTH; i >= 2; i--) ent[i] <= ent[i-1];
         ent[1] <= '{valid: dec_valid & ~stall & ~flush, rd: MAX_RA_W'(dec_rd), rd_we: dec_rd_we,
                     is_load: dec_is_load};
         if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_unit_param.sv
// tb_hazard_unit_param: directed and random checks of two configurations against an instruction-history model.
module tb_hazard_unit_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dec_valid = 1'b0, dec_rd_we = 1'b0, dec_is_load = 1'b0, flush = 1'b0;
   logic [4:0] dec_rd = '0;
   logic [9:0] dec_rs = '0;
   logic [1:0] dec_rs_used = '0;

   logic en_a, bub_a, en_b, bub_b;
   logic [3:0] stage_a;
   logic [5:0] stage_b;
   logic [1:0] dm_a, dm_b;
   logic [31:0] cnt_a;
   logic [2:0] cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_unit_param dut_a (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
      .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used), .flush(flush),
      .f_to_d_enable_ff(en_a), .d_to_e_bubble(bub_a), .fwd_stage(stage_a), .fwd_from_dm(dm_a),
      .stall_cycles(cnt_a)
   );

   hazard_unit_param #(.FWD_DEPTH(4), .LOAD_LATENCY(2), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
      .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used), .flush(flush),
      .f_to_d_enable_ff(en_b), .d_to_e_bubble(bub_b), .fwd_stage(stage_b), .fwd_from_dm(dm_b),
      .stall_cycles(cnt_b)
   );

   // Model: history of issued instructions, age 1 = most recently issued.
   typedef struct {bit v; bit [4:0] rd; bit we; bit ld;} ins_t;
   ins_t hist [2][1:4];
   int depth [2] = '{2, 4};
   int ll [2] = '{1, 2};
   longint cmax [2] = '{64'hFFFF_FFFF, 7};
   longint mcnt [2] = '{0, 0};
   bit e_stall [2];
   int e_stage [2][2];
   bit e_dm [2][2];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Producer of a source = the youngest in-flight instruction writing that (non-zero) register.
   task automatic calc(input int c);
      bit lu;
      bit found;
      bit [4:0] r;
      lu = 0;
      for (int k = 0; k < 2; k++) begin
         e_stage[c][k] = 0;
         e_dm[c][k] = 0;
         r = dec_rs[k*5 +: 5];
         found = 0;
         if (dec_valid && dec_rs_used[k] && r != 0)
            for (int a = 1; a <= depth[c]; a++)
               if (!found && hist[c][a].v && hist[c][a].we && hist[c][a].rd == r) begin
                  found = 1;
                  e_stage[c][k] = a;
                  e_dm[c][k] = hist[c][a].ld;
                  if (hist[c][a].ld && a <= ll[c]) lu = 1;
               end
      end
      e_stall[c] = lu && !flush;
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int c = 0; c < 2; c++) begin
         if (!rst_n) begin
            for (int a = 1; a <= 4; a++) hist[c][a] = '{0, 0, 0, 0};
            mcnt[c] = 0;
         end else begin
            calc(c);
            if (e_stall[c] && mcnt[c] < cmax[c]) mcnt[c]++;
            for (int a = 4; a >= 2; a--) hist[c][a] = hist[c][a-1];
            hist[c][1] = '{dec_valid && !e_stall[c] && !flush, dec_rd, dec_rd_we, dec_is_load};
         end
      end
   end

   always @(negedge clk) begin
      calc(0);
      calc(1);
      chk("model_en_a", en_a, !e_stall[0]);
      chk("model_bub_a", bub_a, e_stall[0] || flush);
      chk("model_cnt_a", cnt_a, mcnt[0]);
      chk("model_en_b", en_b, !e_stall[1]);
      chk("model_bub_b", bub_b, e_stall[1] || flush);
      chk("model_cnt_b", cnt_b, mcnt[1]);
      for (int k = 0; k < 2; k++) begin
         if (!e_stall[0]) begin
            chk("model_stage_a", stage_a[k*2 +: 2], e_stage[0][k]);
            chk("model_dm_a", dm_a[k], e_dm[0][k]);
         end
         if (!e_stall[1]) begin
            chk("model_stage_b", stage_b[k*3 +: 3], e_stage[1][k]);
            chk("model_dm_b", dm_b[k], e_dm[1][k]);
         end
      end
   end

   task automatic drive(input bit v, input bit [4:0] rd, input bit we, input bit ld, input bit [4:0] r0,
                        input bit [4:0] r1, input bit [1:0] u, input bit fl);
      dec_valid = v;
      dec_rd = rd;
      dec_rd_we = we;
      dec_is_load = ld;
      dec_rs = {r1, r0};
      dec_rs_used = u;
      flush = fl;
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic bubbles;
      drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
      repeat (5) nxt;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_en", en_a, 1);
      chk("rst_bub", bub_a, 0);
      chk("rst_stage", stage_a, 0);
      chk("rst_dm", dm_a, 0);
      chk("rst_cnt", cnt_a, 0);
      nxt;
      rst_n = 1'b1;
      bubbles;
      // add x5, then read x5
      drive(1, 5, 1, 0, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 0, 0, 0, 5, 0, 2'b01, 0);
      @(negedge clk);
      chk("t1_stage", stage_a[1:0], 1);
      chk("t1_dm", dm_a[0], 0);
      chk("t1_en", en_a, 1);
      nxt;
      bubbles;
      // lw x6 then use: 1 stall on depth 2, 2 stalls on depth 4
      drive(1, 6, 1, 1, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 0, 0, 0, 6, 0, 2'b01, 0);
      @(negedge clk);
      chk("t2_en0", en_a, 0);
      chk("t2_bub0", bub_a, 1);
      chk("t6_en0", en_b, 0);
      nxt;
      @(negedge clk);
      chk("t2_en1", en_a, 1);
      chk("t2_bub1", bub_a, 0);
      chk("t2_stage", stage_a[1:0], 2);
      chk("t2_dm", dm_a[0], 1);
      chk("t2_cnt", cnt_a, 1);
      chk("t6_en1", en_b, 0);
      nxt;
      @(negedge clk);
      chk("t6_en2", en_b, 1);
      chk("t6_stage", stage_b[2:0], 3);
      chk("t6_dm", dm_b[0], 1);
      chk("t6_cnt", cnt_b, 2);
      nxt;
      bubbles;
      // two writers of x7, youngest wins for both sources
      drive(1, 7, 1, 0, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 7, 1, 0, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 0, 0, 0, 7, 7, 2'b11, 0);
      @(negedge clk);
      chk("t3_stage0", stage_a[1:0], 1);
      chk("t3_stage1", stage_a[3:2], 1);
      nxt;
      bubbles;
      // x0 writer and a non-writing x3 never forward
      drive(1, 3, 0, 0, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 0, 1, 0, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 0, 0, 0, 0, 3, 2'b11, 0);
      @(negedge clk);
      chk("t4_stage", stage_a, 0);
      chk("t4_en", en_a, 1);
      nxt;
      bubbles;
      // lw x8, then flushed use that also writes x8
      drive(1, 8, 1, 1, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 8, 1, 0, 8, 0, 2'b01, 1);
      @(negedge clk);
      chk("t5_en", en_a, 1);
      chk("t5_bub", bub_a, 1);
      nxt;
      drive(1, 0, 0, 0, 8, 0, 2'b01, 0);
      @(negedge clk);
      chk("t5_stage", stage_a[1:0], 2);
      chk("t5_dm", dm_a[0], 1);
      chk("t5_cnt", cnt_a, 1);
      nxt;
      bubbles;
      // reset in the middle of a load-use stall
      drive(1, 9, 1, 1, 0, 0, 2'b00, 0);
      nxt;
      drive(1, 0, 0, 0, 9, 0, 2'b01, 0);
      @(negedge clk);
      chk("t6r_en_pre", en_b, 0);
      chk("t6r_bub_pre", bub_b, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6r_en", en_b, 1);
      chk("t6r_bub", bub_b, 0);
      chk("t6r_cnt", cnt_b, 0);
      chk("t6r_en_a", en_a, 1);
      nxt;
      rst_n = 1'b1;
      // random traffic over a small register range to provoke dense hazards
      repeat (3000) begin
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom), $urandom_range(0, 9) == 0);
         rst_n = $urandom_range(0, 299) != 0;
         nxt;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
